// File: rtl/img_pkg.sv
// Shared types and defaults for the image line arbiter.
package img_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StGap,
    StDone
  } arb_state_t;

  localparam int unsigned GAP_CYC_DEFAULT = 4;

  typedef logic ch_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter; the pointer names the channel preferred on a tie.
module rr_arbiter2
  import img_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       i_clr,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  ch_idx_t    i_upd_ch,
  output logic       o_vld,
  output ch_idx_t    o_gnt
);

  ch_idx_t r_ptr;

  always_comb begin
    o_vld = |i_req;
    o_gnt = (i_req[0] & i_req[1]) ? r_ptr : i_req[1];
  end

  // After serving a channel, the other one wins the next tie.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_clr) begin
      r_ptr <= 1'b0;
    end else if (i_upd) begin
      r_ptr <= ~i_upd_ch;
    end
  end

endmodule

// File: rtl/image_line_arbiter.sv
// Merges whole-line bursts from two line FIFOs into one tagged stream, round-robin,
// with per-channel row tracking, frame completion and error flags.
module image_line_arbiter
  import img_pkg::*;
#(
  parameter int unsigned DATA_W  = 80,
  parameter int unsigned COL_W   = 9,
  parameter int unsigned ROW_W   = 16,
  parameter int unsigned GAP_CYC = GAP_CYC_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              new_frame,
  input  logic [COL_W-1:0]  line_words,
  input  logic [ROW_W-1:0]  frame_rows,
  input  logic [1:0]        ch_line_rdy,
  input  logic [1:0]        ch_empty,
  output logic [1:0]        ch_rd_en,
  input  logic [DATA_W-1:0] ch0_dout,
  input  logic [DATA_W-1:0] ch1_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_ch,
  output logic              frame_done,
  output logic              underrun,
  output logic              cfg_err,
  output logic              busy
);

  arb_state_t             r_state, w_state_nxt;
  logic                   r_armed;
  logic [COL_W-1:0]       r_line_words, r_col;
  logic [ROW_W-1:0]       r_frame_rows;
  logic [1:0][ROW_W-1:0]  r_row;
  ch_idx_t                r_gnt;
  logic [3:0]             r_gap;
  logic                   r_underrun, r_cfg_err, r_frame_done;
  logic                   r_s1_vld, r_s1_sof, r_s1_eol;
  ch_idx_t                r_s1_ch;
  logic [DATA_W-1:0]      r_out_data;
  logic                   r_out_vld, r_out_sof, r_out_eol, r_out_ch;

  logic [1:0] w_elig;
  logic       w_all_done, w_rd, w_last, w_cfg_bad, w_gnt_vld;
  ch_idx_t    w_gnt;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_elig[c] = ch_line_rdy[c] & ~ch_empty[c] & (r_row[c] < r_frame_rows);
    end
    w_all_done = (r_row[0] == r_frame_rows) & (r_row[1] == r_frame_rows);
    w_rd       = (r_state == StBurst) & ~ch_empty[r_gnt] & ~new_frame;
    w_last     = (r_col == r_line_words - COL_W'(1));
    w_cfg_bad  = (line_words == '0) | (frame_rows == '0);
    ch_rd_en   = w_rd ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
  end

  rr_arbiter2 u_rr (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_clr     (new_frame),
    .i_req     (w_elig),
    .i_upd     (w_rd & w_last),
    .i_upd_ch  (r_gnt),
    .o_vld     (w_gnt_vld),
    .o_gnt     (w_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (r_armed) begin
          if (w_all_done)     w_state_nxt = StDone;
          else if (w_gnt_vld) w_state_nxt = StBurst;
        end
      end
      StBurst: if (w_rd && w_last) w_state_nxt = StGap;
      StGap:   if (r_gap == 4'(GAP_CYC - 1)) w_state_nxt = StIdle;
      StDone:  w_state_nxt = StDone;
      default: w_state_nxt = StIdle;
    endcase
    if (new_frame) w_state_nxt = w_cfg_bad ? StDone : StIdle;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= StIdle;
      r_armed      <= 1'b0;
      r_line_words <= '0;
      r_frame_rows <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_gnt        <= 1'b0;
      r_gap        <= '0;
      r_underrun   <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= (w_state_nxt == StDone) & (r_state != StDone) & ~new_frame;
      if (new_frame) begin
        r_armed      <= 1'b1;
        r_line_words <= line_words;
        r_frame_rows <= frame_rows;
        r_col        <= '0;
        r_row        <= '0;
        r_gap        <= '0;
        r_underrun   <= 1'b0;
        r_cfg_err    <= w_cfg_bad;
      end else begin
        unique case (r_state)
          StIdle: if (w_state_nxt == StBurst) r_gnt <= w_gnt;
          StBurst: begin
            if (ch_empty[r_gnt]) r_underrun <= 1'b1;
            if (w_rd) begin
              if (w_last) begin
                r_col        <= '0;
                r_row[r_gnt] <= r_row[r_gnt] + ROW_W'(1);
                r_gap        <= '0;
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end
          end
          StGap:   r_gap <= r_gap + 4'd1;
          default: ;
        endcase
      end
    end
  end

  // Two-stage output pipe: sideband computed at issue, data captured when the FIFO presents it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s1_ch    <= 1'b0;
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
      r_out_sof  <= 1'b0;
      r_out_eol  <= 1'b0;
      r_out_ch   <= 1'b0;
    end else begin
      r_s1_vld <= w_rd;
      r_s1_sof <= (r_col == '0) & (r_row[r_gnt] == '0);
      r_s1_eol <= w_last;
      r_s1_ch  <= r_gnt;
      if (new_frame) begin
        r_out_vld <= 1'b0;
        r_out_sof <= 1'b0;
        r_out_eol <= 1'b0;
      end else begin
        r_out_vld <= r_s1_vld;
        r_out_sof <= r_s1_vld & r_s1_sof;
        r_out_eol <= r_s1_vld & r_s1_eol;
        if (r_s1_vld) begin
          r_out_ch   <= r_s1_ch;
          r_out_data <= r_s1_ch ? ch1_dout : ch0_dout;
        end
      end
    end
  end

  always_comb begin
    out_data   = r_out_data;
    out_vld    = r_out_vld;
    out_sof    = r_out_sof;
    out_eol    = r_out_eol;
    out_ch     = r_out_ch;
    frame_done = r_frame_done;
    underrun   = r_underrun;
    cfg_err    = r_cfg_err;
    busy       = (r_state == StBurst) | (r_state == StGap);
  end

endmodule

// File: tb/tb_image_line_arbiter.sv
// Scoreboard bench for image_line_arbiter: behavioural FIFOs feed the DUT, a monitor
// pops expected words whenever out_vld is seen.
module tb_image_line_arbiter;

  localparam int DW = 80;
  localparam int CW = 9;
  localparam int RW = 16;
  localparam int GC = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          new_frame = 1'b0;
  logic [CW-1:0] line_words = '0;
  logic [RW-1:0] frame_rows = '0;
  logic [1:0]    ch_line_rdy = '0;
  logic [1:0]    ch_empty;
  logic [1:0]    ch_rd_en;
  logic [DW-1:0] ch0_dout = '0;
  logic [DW-1:0] ch1_dout = '0;
  logic [DW-1:0] out_data;
  logic          out_vld, out_sof, out_eol, out_ch;
  logic          frame_done, underrun, cfg_err, busy;

  image_line_arbiter #(
    .DATA_W  (DW),
    .COL_W   (CW),
    .ROW_W   (RW),
    .GAP_CYC (GC)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .new_frame   (new_frame),
    .line_words  (line_words),
    .frame_rows  (frame_rows),
    .ch_line_rdy (ch_line_rdy),
    .ch_empty    (ch_empty),
    .ch_rd_en    (ch_rd_en),
    .ch0_dout    (ch0_dout),
    .ch1_dout    (ch1_dout),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .out_ch      (out_ch),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .cfg_err     (cfg_err),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural FIFOs: read enable sampled mid-cycle, data presented after the edge.
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  int            wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  logic [1:0]    frc = '0;
  logic          clr = 1'b0;
  logic [1:0]    rd_s = '0;

  assign ch_empty[0] = (wp0 == rp0) | frc[0];
  assign ch_empty[1] = (wp1 == rp1) | frc[1];

  always @(negedge sys_clk) rd_s <= ch_rd_en;

  always @(posedge sys_clk) begin
    if (clr) begin
      rp0 <= wp0;
      rp1 <= wp1;
    end else begin
      if (rd_s[0]) begin
        ch0_dout <= mem0[rp0];
        rp0      <= rp0 + 1;
      end
      if (rd_s[1]) begin
        ch1_dout <= mem1[rp1];
        rp1      <= rp1 + 1;
      end
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
    logic          ch;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   fd_cnt = 0;
  int   last_eol = -1;
  logic gap_en = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] word(input int c, input int line, input int col);
    return {56'h0, 8'(8'hA0 + c), 8'(line), 8'(col)};
  endfunction

  task automatic fill(input int c, input int line, input int lw);
    for (int k = 0; k < lw; k++) begin
      if (c == 0) begin
        mem0[wp0] = word(c, line, k);
        wp0++;
      end else begin
        mem1[wp1] = word(c, line, k);
        wp1++;
      end
    end
  endtask

  task automatic push_line(input int c, input int line, input int lw);
    exp_t e;
    fill(c, line, lw);
    for (int k = 0; k < lw; k++) begin
      e.d   = word(c, line, k);
      e.sof = (line == 0) && (k == 0);
      e.eol = (k == lw - 1);
      e.ch  = 1'(c);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic nf(input int lw, input int fr);
    step();
    line_words = CW'(lw);
    frame_rows = RW'(fr);
    new_frame  = 1'b1;
    step();
    new_frame  = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge sys_clk);
    chk(nm, DW'(exp_q.size()), '0);
    exp_q.delete();
  endtask

  task automatic wait_rd0(input string nm);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (ch_rd_en[0]) break;
    end
    chk(nm, DW'(i < 100), DW'(1));
  endtask

  task automatic clear_fifos();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Monitor: FIFO read legality, frame_done counting, output scoreboard, burst gaps.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (frame_done) fd_cnt++;
      if (ch_rd_en != 2'b00) chk("rd_while_empty", DW'(ch_rd_en & ch_empty), '0);
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got data=%0h ch=%0d, required no output (t=%0t)",
                   out_data, out_ch, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_sof", DW'(out_sof), DW'(e.sof));
          chk("out_eol", DW'(out_eol), DW'(e.eol));
          chk("out_ch", DW'(out_ch), DW'(e.ch));
        end
        if (gap_en && last_eol >= 0) begin
          chk("burst_gap_ok", DW'((cyc - last_eol - 1) >= GC + 1), DW'(1));
          last_eol = -1;
        end
        if (out_eol) last_eol = cyc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rds;
    // Reset state
    #12;
    chk("reset_outputs", {ch_rd_en, out_vld, out_sof, out_eol, out_ch, frame_done, underrun,
                          cfg_err, busy, out_data[7:0]}, '0);
    step();
    sys_rst_n = 1'b1;
    step();

    // Single channel source, then the second channel completes the frame
    nf(4, 2);
    push_line(0, 0, 4);
    push_line(0, 1, 4);
    ch_line_rdy = 2'b01;
    wait_drain("t1_ch0_drain");
    repeat (12) step();
    chk("t1_no_done_yet", DW'(fd_cnt), DW'(0));
    push_line(1, 0, 4);
    push_line(1, 1, 4);
    ch_line_rdy = 2'b11;
    wait_drain("t1_ch1_drain");
    repeat (12) step();
    chk("t1_done_once", DW'(fd_cnt), DW'(1));
    chk("t1_idle_busy", DW'(busy), DW'(0));

    // Both channels ready: alternate ch0, ch1, ch0, ch1 with full gaps
    ch_line_rdy = 2'b00;
    nf(3, 2);
    push_line(0, 0, 3);
    push_line(1, 0, 3);
    push_line(0, 1, 3);
    push_line(1, 1, 3);
    last_eol = -1;
    gap_en = 1'b1;
    ch_line_rdy = 2'b11;
    wait_drain("t2_drain");
    repeat (12) step();
    gap_en = 1'b0;
    chk("t2_done", DW'(fd_cnt), DW'(2));

    // FIFO goes empty mid-burst
    ch_line_rdy = 2'b00;
    nf(4, 1);
    chk("t3_underrun_clr", DW'(underrun), DW'(0));
    base = rp0;
    push_line(0, 0, 4);
    ch_line_rdy = 2'b01;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (rp0 - base >= 2) break;
    end
    @(posedge sys_clk);
    #1;
    frc[0] = 1'b1;
    repeat (3) begin
      @(negedge sys_clk);
      chk("t3_stall_rd", DW'(ch_rd_en), DW'(0));
    end
    chk("t3_underrun", DW'(underrun), DW'(1));
    step();
    frc[0] = 1'b0;
    wait_drain("t3_drain");
    chk("t3_underrun_sticky", DW'(underrun), DW'(1));

    // new_frame in the second word of a burst
    ch_line_rdy = 2'b00;
    nf(2, 2);
    push_line(0, 0, 2);
    ch_line_rdy = 2'b01;
    wait_drain("t4_first_line");
    fill(0, 1, 2);
    wait_rd0("t4_burst_start");
    @(posedge sys_clk);
    #1;
    new_frame   = 1'b1;
    ch_line_rdy = 2'b00;
    @(negedge sys_clk);
    chk("t4_nf_rd_en", DW'(ch_rd_en), DW'(0));
    @(posedge sys_clk);
    #1;
    new_frame = 1'b0;
    @(negedge sys_clk);
    chk("t4_flush_n1", DW'(out_vld), DW'(0));
    @(negedge sys_clk);
    chk("t4_flush_n2", DW'(out_vld), DW'(0));
    clear_fifos();
    push_line(0, 0, 2);
    push_line(1, 0, 2);
    ch_line_rdy = 2'b11;
    wait_drain("t4_regrant_ch0");

    // Illegal configuration
    ch_line_rdy = 2'b00;
    nf(0, 2);
    @(negedge sys_clk);
    chk("t5_cfg_err", DW'(cfg_err), DW'(1));
    chk("t5_not_busy", DW'(busy), DW'(0));
    fill(0, 0, 2);
    step();
    ch_line_rdy = 2'b01;
    rds = 0;
    repeat (6) begin
      @(negedge sys_clk);
      if (ch_rd_en != 2'b00) rds++;
    end
    chk("t5_no_reads", DW'(rds), DW'(0));
    step();
    ch_line_rdy = 2'b00;
    nf(2, 1);
    @(negedge sys_clk);
    chk("t5_cfg_err_clr", DW'(cfg_err), DW'(0));
    clear_fifos();

    // Asynchronous reset in the middle of a burst
    nf(4, 1);
    push_line(0, 0, 4);
    ch_line_rdy = 2'b01;
    wait_rd0("t6_burst_start");
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {ch_rd_en, out_vld, out_sof, out_eol, out_ch, frame_done, underrun,
                             cfg_err, busy}, '0);
    exp_q.delete();
    base = rp0;
    step();
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("t6_no_reads", DW'(rp0 - base), DW'(0));
    chk("t6_not_busy", DW'(busy), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
